cmd_uart_wrapper: RTL
=====================

# cmd_uart_wrapper

Knight-side endpoint of the remote command link. It receives 16-bit commands as two UART bytes (high byte first) from the remote/BLE side and presents them to the command processor as `cmd` with a `cmd_rdy` flag. It also serializes the processor's 8-bit response (for example 8'hA5 on completion) back over TX. It sits between the RX/TX pins of the top level and `cmd_proc`, and is the counterpart of the remote's command sender.

## Interface
- `BAUD_DIV`, default 434: clocks per bit (50 MHz / 115200 baud). Must be ≥ 16.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `RX`  in  1  serial input, idle high, asynchronous to `clk`.
- `TX`  out  1  serial output, idle high.
- `cmd`  out  16  last complete command, {first byte, second byte}.
- `cmd_rdy`  out  1  a complete, unconsumed command is in `cmd`.
- `clr_cmd_rdy`  in  1  consumer acknowledge; clears `cmd_rdy`.
- `resp`  in  8  response byte, sampled when `trmt` is high.
- `trmt`  in  1  one-cycle request to transmit `resp`.
- `tx_done`  out  1  previous response frame has completed.

## Operation
- **Frame format (both directions):** 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). No parity.
- **RX synchronizer:** `RX` passes through 2 flops that reset to 1. All RX logic uses the synchronized value.
- **RX FSM states:** IDLE, START, DATA, STOP.
  - IDLE → START on a synchronized falling edge. The baud counter loads BAUD_DIV/2.
  - START: at count expiry, if the line is high, treat it as a false start and return to IDLE. Otherwise reload BAUD_DIV and go to DATA.
  - DATA: shift in 8 samples, one per bit time, each at mid-bit, then go to STOP.
  - STOP: sample at mid-bit. A sample of 1 produces a valid byte. A sample of 0 is a framing error: discard the byte and reset byte pairing. Either outcome returns to IDLE.
- **Byte pairing:** a 1-bit flag tracks whether a high byte is held.
  - Valid byte with no high byte held: store it as the high byte.
  - Valid byte with a high byte held: load `cmd` = {high, low}, set `cmd_rdy`, clear the flag.
- **`cmd_rdy` clearing:**
  - Cleared by `clr_cmd_rdy`.
  - Also cleared on the start edge of the next command's high byte.
  - `cmd` itself holds until the next complete pair.
- **TX FSM states:** IDLE, XMIT.
  - In IDLE, `trmt` loads the 10-bit frame shift register {1, resp, 0}, clears `tx_done`, and enters XMIT.
  - XMIT shifts out one bit per BAUD_DIV clocks. After the 10th bit time it sets `tx_done` and returns to IDLE.
  - `trmt` during XMIT is ignored. The pending frame is unaffected.
- **Full duplex:** RX and TX are fully independent.

## Timing
- **Reset values:** `TX`=1, `cmd`=0, `cmd_rdy`=0, `tx_done`=0, both FSMs IDLE, pairing flag clear, synchronizer flops 1.
- **Reset mid-frame:** abort immediately. `TX`=1 on the cycle after `rst` is sampled high, and partial bytes are lost.
- **Bit timing:** one bit = BAUD_DIV clocks; one frame = 10·BAUD_DIV clocks.
- **TX latency:**
  - `TX` drops to 0 on the cycle after `trmt` is sampled.
  - `tx_done` rises exactly 10·BAUD_DIV clocks after `TX` first goes low.
- **RX latency:**
  - A valid byte is recognized at the stop-bit mid-sample, which is 9.5·BAUD_DIV (±1) clocks after the RX falling edge plus 2 synchronizer cycles.
  - `cmd_rdy` rises the cycle after the second byte's stop sample.
- **Simultaneous `clr_cmd_rdy` and a new command completing on the same cycle:** completion wins; `cmd_rdy`=1 with the new `cmd`.
- **Baud counter width:** `$clog2(BAUD_DIV)` bits. The counter counts down and reloads on expiry; no wrap artifacts.

## Test plan
- **Command receive:** send bytes 8'h2E then 8'h11 at 434 clk/bit → `cmd`=16'h2E11, `cmd_rdy`=1 within ~4343 clks after the second start edge. Then pulse `clr_cmd_rdy` → `cmd_rdy`=0 next cycle, `cmd` holds 16'h2E11.
- **Response transmit:** `resp`=8'hA5 with a `trmt` pulse → `TX` bit sequence 0,1,0,1,0,0,1,0,1,1, each held 434 clks. `tx_done`=1 at 4340 clks. A second `trmt` issued mid-frame changes nothing.
- **Framing error:** send 8'h2E with stop bit 0, then 8'h40, 8'h07 → `cmd`=16'h4007. The 2E byte is discarded, and `cmd_rdy` is not set until after 8'h07.
- **Glitch rejection:** drive `RX` low for 100 clks (less than BAUD_DIV/2), then high → RX returns to IDLE and no byte is produced. A following valid pair still decodes correctly.
- **Reset:** assert `rst` mid-TX frame and mid-RX byte → `TX`=1 and `cmd_rdy`=0 the next cycle. The next full pair decodes from the high byte.
- **Full duplex:** transmit 8'hA5 while receiving 16'h1234 concurrently → both complete correctly, with no timing interaction.

Source files
------------

// File: rtl/cmd_uart_wrapper.sv
// Knight-side UART endpoint: pairs two received bytes (high first) into a 16-bit
// command with a ready flag, and serializes 8-bit responses back over TX.
module cmd_uart_wrapper #(
    parameter int BAUD_DIV = 434
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RX,
    output logic        TX,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        trmt,
    output logic        tx_done
);
    localparam int CW = $clog2(BAUD_DIV);
    // Counters run down to zero, so a load of N-1 spans N clocks.
    localparam logic [CW-1:0] FULL = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic {TX_IDLE, TX_XMIT} tx_state_t;

    rx_state_t       rx_state, rx_nxt;
    logic            rx_s1, rx_s2, rx_prev;
    logic [CW-1:0]   rx_cnt;
    logic [2:0]      rx_bits;
    logic [7:0]      rx_sr, hi_byte;
    logic            hi_held;
    logic            rx_fall, rx_exp, stop_smp, cmd_done;

    tx_state_t       tx_state, tx_nxt;
    logic [CW-1:0]   tx_cnt;
    logic [3:0]      tx_bits;
    logic [9:0]      tx_sr;
    logic            tx_exp;

    assign rx_fall  = rx_prev & ~rx_s2;
    assign rx_exp   = (rx_cnt == '0);
    assign stop_smp = (rx_state == RX_STOP) && rx_exp;
    assign cmd_done = stop_smp && rx_s2 && hi_held;
    assign tx_exp   = (tx_cnt == '0);
    assign TX       = tx_sr[0];

    always_comb begin
        rx_nxt = rx_state;
        case (rx_state)
            RX_IDLE:  if (rx_fall) rx_nxt = RX_START;
            RX_START: if (rx_exp) rx_nxt = rx_s2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_exp && rx_bits == 3'd7) rx_nxt = RX_STOP;
            RX_STOP:  if (rx_exp) rx_nxt = RX_IDLE;
            default:  rx_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state <= RX_IDLE;
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_prev  <= 1'b1;
            rx_cnt   <= HALF;
            rx_bits  <= '0;
            rx_sr    <= '0;
            hi_byte  <= '0;
            hi_held  <= 1'b0;
            cmd      <= '0;
            cmd_rdy  <= 1'b0;
        end else begin
            rx_s1    <= RX;
            rx_s2    <= rx_s1;
            rx_prev  <= rx_s2;
            rx_state <= rx_nxt;

            if (rx_state == RX_IDLE) begin
                rx_cnt  <= HALF;
                rx_bits <= '0;
            end else if (rx_exp) begin
                rx_cnt <= FULL;
            end else begin
                rx_cnt <= rx_cnt - CW'(1);
            end

            if (rx_state == RX_DATA && rx_exp) begin
                rx_sr   <= {rx_s2, rx_sr[7:1]};
                rx_bits <= rx_bits + 3'd1;
            end

            // A bad stop bit drops the byte and any held high byte.
            if (stop_smp) begin
                if (!rx_s2) begin
                    hi_held <= 1'b0;
                end else if (!hi_held) begin
                    hi_byte <= rx_sr;
                    hi_held <= 1'b1;
                end else begin
                    cmd     <= {hi_byte, rx_sr};
                    hi_held <= 1'b0;
                end
            end

            if (cmd_done)
                cmd_rdy <= 1'b1;
            else if (clr_cmd_rdy || (rx_state == RX_IDLE && rx_fall && !hi_held))
                cmd_rdy <= 1'b0;
        end
    end

    always_comb begin
        tx_nxt = tx_state;
        case (tx_state)
            TX_IDLE: if (trmt) tx_nxt = TX_XMIT;
            TX_XMIT: if (tx_exp && tx_bits == 4'd9) tx_nxt = TX_IDLE;
            default: tx_nxt = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= FULL;
            tx_bits  <= '0;
            tx_sr    <= '1;
            tx_done  <= 1'b0;
        end else begin
            tx_state <= tx_nxt;
            if (tx_state == TX_IDLE) begin
                tx_cnt  <= FULL;
                tx_bits <= '0;
                if (trmt) begin
                    tx_sr   <= {1'b1, resp, 1'b0};
                    tx_done <= 1'b0;
                end
            end else if (tx_exp) begin
                // Shifting in ones leaves the line idle-high once the frame is out.
                tx_cnt  <= FULL;
                tx_sr   <= {1'b1, tx_sr[9:1]};
                tx_bits <= tx_bits + 4'd1;
                if (tx_bits == 4'd9) tx_done <= 1'b1;
            end else begin
                tx_cnt <= tx_cnt - CW'(1);
            end
        end
    end
endmodule
